blit2d_engine: RTL and testbench
================================

Name: blit2d_engine

Overview:
Parametrised 2D blitter for Xosera VRAM. Registers are loaded through the existing register-write strobe interface. On start, the engine fills or copies a rectangle of WIDTH words × LINES lines, with independent source and destination line modulos. It shares VRAM with video generation and only commits accesses in blit slots (blit_cycle_i=1).

Parameters:
ADDR_W, 16, VRAM address width; all address arithmetic wraps modulo 2^ADDR_W
DATA_W, 16, VRAM and register data width
CNT_W, 16, width of WIDTH and LINES counters

Ports:
clk  in  1  system clock
reset_n_i  in  1  asynchronous, active-low reset
blit_cycle_i  in  1  1 = blitter VRAM slot this cycle, 0 = video slot
reg_write_strobe_i  in  1  one-cycle register write strobe
reg_num_i  in  4  register number
reg_data_i  in  DATA_W  register write data
blit_vram_sel_o  out  1  VRAM select
blit_vram_wr_o  out  1  1 = write, 0 = read
blit_vram_addr_o  out  ADDR_W  VRAM address
blit_vram_data_o  out  DATA_W  VRAM write data
blit_vram_data_i  in  DATA_W  VRAM read data, valid the cycle after a committed read
busy_o  out  1  operation in progress
done_o  out  1  one-cycle pulse on completion or abort

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
- Output reset values: sel/wr=0, addr=0, data_o=0, busy_o=0, done_o=0. Reset also clears all registers to 0 and sets state to IDLE.
- Register map (reg_num_i), with address registers taking the low ADDR_W bits:
  - 0 RD_ADDR, 1 WR_ADDR, 2 RD_MOD, 3 WR_MOD, 4 WIDTH, 5 LINES, 6 FILL_DATA.
  - 7 CTRL: bit0 start, bit1 mode (0 fill, 1 copy), bit2 transparent, bit15 abort.
- Register writes while busy_o=1 are ignored, except a CTRL write with bit15=1.
- Commit rule: an access is committed on a cycle where sel_o=1 and blit_cycle_i=1. While sel_o=1 and blit_cycle_i=0, sel/wr/addr/data_o hold unchanged.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE:
  - CTRL start with WIDTH≠0 and LINES≠0: load working addresses and counters, set busy_o=1 next cycle, go to WR_REQ (fill) or RD_REQ (copy).
  - Start with WIDTH=0 or LINES=0: no VRAM access; go to DONE.
- RD_REQ: drive sel=1, wr=0, addr=rd_ptr; on commit go to RD_WAIT.
- RD_WAIT: capture blit_vram_data_i into the source latch; go to WR_REQ.
- WR_REQ: drive sel=1, wr=1, addr=wr_ptr, data_o = FILL_DATA (fill) or source latch (copy). On commit, step:
  - Not last word of line: ptr += 1.
  - Last word of line: ptr += 1 + MOD, and decrement the line counter.
  - Last word of last line: go to DONE.
  - Otherwise return to RD_REQ (copy) or stay in WR_REQ (fill).
- DONE: done_o=1 for one cycle, busy_o=0, return to IDLE.
- Throughput with blit_cycle_i=1 continuously: fill 1 word/cycle; copy 1 word per 3 cycles.
- Abort (CTRL bit15 while busy): deassert sel/wr next cycle, go to DONE. An in-flight committed read is discarded and no further writes occur.
- Start and abort in the same CTRL write: abort wins when busy; start wins when idle.
- Pointer arithmetic is unsigned modulo 2^ADDR_W. MOD may encode negative strides via two's complement.
- Asynchronous reset mid-operation returns the engine to IDLE immediately with outputs at reset values.

Optional Feature:
BLIT_TRANSPARENT_EN.
- Defined: in copy mode with CTRL bit2=1, a source word equal to FILL_DATA is not written. Pointers still step, and sel_o is not asserted for that word, so no slot is consumed.
- Undefined: CTRL bit2 is ignored and every word is written.

Test Plan:
- Fill: WR_ADDR=0x0100, WR_MOD=5, WIDTH=3, LINES=2, FILL_DATA=0x1F20, blit_cycle_i=1 -> writes 0x1F20 to 0x0100, 0x0101, 0x0102, 0x0108, 0x0109, 0x010A; done_o pulses once; busy_o is high 6 cycles.
- Copy: preload VRAM 0x0010–0x0011 = 0xAAAA, 0xBBBB; RD_ADDR=0x0010, WR_ADDR=0x2000, WIDTH=2, LINES=1 -> reads 0x0010 then 0x0011; writes 0x2000=0xAAAA, 0x2001=0xBBBB.
- Arbitration: fill WIDTH=4 with blit_cycle_i toggling 0/1 -> sel/addr/data held stable across video slots; exactly 4 writes, each on a blit slot.
- Wrap and zero-size: WR_ADDR=0xFFFF, WIDTH=2, LINES=1 -> writes 0xFFFF, then 0x0000. A start with WIDTH=0 -> no sel_o, and done_o pulses 1 cycle after start.
- Abort: fill WIDTH=100, LINES=1; write CTRL=0x8000 after the 10th write -> sel_o=0 next cycle, done_o pulses, no 11th write, and a later start succeeds.
- Transparency (macro defined): copy source {0x0000, 0x1234, 0x0000} with FILL_DATA=0x0000 and bit2=1 -> only dest+1 is written with 0x1234. With the macro undefined -> all 3 words are written.

Source files
------------

// File: rtl/blit2d_engine.sv
// blit2d_engine: rectangle fill/copy engine for Xosera VRAM.
//
// Registers are loaded over the register-write strobe port. A CTRL start
// fills or copies WIDTH words x LINES lines, stepping source and destination
// pointers with independent line modulos. VRAM accesses are only committed in
// blitter slots (blit_cycle_i=1); in video slots the request is held.
//
// Optional build macro: BLIT_TRANSPARENT_EN
//   When defined, copy mode with CTRL bit2 set skips writing any source word
//   equal to FILL_DATA (pointers still step, no VRAM slot is used).
//   When undefined, CTRL bit2 is ignored.
module blit2d_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              blit_cycle_i,
  input  logic              reg_write_strobe_i,
  input  logic [3:0]        reg_num_i,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic              blit_vram_sel_o,
  output logic              blit_vram_wr_o,
  output logic [ADDR_W-1:0] blit_vram_addr_o,
  output logic [DATA_W-1:0] blit_vram_data_o,
  input  logic [DATA_W-1:0] blit_vram_data_i,
  output logic              busy_o,
  output logic              done_o
);

  // Register numbers
  localparam logic [3:0] REG_RD_ADDR = 4'd0;
  localparam logic [3:0] REG_WR_ADDR = 4'd1;
  localparam logic [3:0] REG_RD_MOD  = 4'd2;
  localparam logic [3:0] REG_WR_MOD  = 4'd3;
  localparam logic [3:0] REG_WIDTH   = 4'd4;
  localparam logic [3:0] REG_LINES   = 4'd5;
  localparam logic [3:0] REG_FILL    = 4'd6;
  localparam logic [3:0] REG_CTRL    = 4'd7;

  // Engine states
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // Programmed registers
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q, rd_mod_q, wr_mod_q;
  logic [CNT_W-1:0]  width_q, lines_q;
  logic [DATA_W-1:0] fill_q;

  // Working state
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d, line_cnt_q, line_cnt_d;
  logic [DATA_W-1:0] src_q, src_d;
  logic              mode_q, mode_d;

  logic busy;
  logic reg_wr_en;
  logic ctrl_wr;
  logic start_req;
  logic abort_req;
  logic skip_wr;
  logic step;
  logic line_end;

  // Pointer advance: +1 within a line, +1+modulo at the end of a line.
  // The modulo may be a two's complement negative stride; the sum wraps naturally.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] ptr,
                                                 input logic              at_line_end,
                                                 input logic [ADDR_W-1:0] mod);
    next_ptr = ptr + ADDR_W'(1) + (at_line_end ? mod : '0);
  endfunction

  assign busy      = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT) || (state_q == S_WR_REQ);
  assign reg_wr_en = reg_write_strobe_i && !busy;
  assign ctrl_wr   = reg_write_strobe_i && (reg_num_i == REG_CTRL);
  // Abort only matters while busy; when idle a start in the same write wins.
  assign start_req = ctrl_wr && reg_data_i[0] && !busy;
  assign abort_req = ctrl_wr && reg_data_i[15] && busy;

`ifdef BLIT_TRANSPARENT_EN
  logic transp_q, transp_d;
  assign skip_wr = (state_q == S_WR_REQ) && mode_q && transp_q && (src_q == fill_q);
`else
  assign skip_wr = 1'b0;
`endif

  assign line_end = (word_cnt_q == CNT_W'(1));

  // Register file: writes are accepted only while the engine is not busy
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_mod_q  <= '0;
      wr_mod_q  <= '0;
      width_q   <= '0;
      lines_q   <= '0;
      fill_q    <= '0;
    end else if (reg_wr_en) begin
      case (reg_num_i)
        REG_RD_ADDR: rd_addr_q <= ADDR_W'(reg_data_i);
        REG_WR_ADDR: wr_addr_q <= ADDR_W'(reg_data_i);
        REG_RD_MOD:  rd_mod_q  <= ADDR_W'(reg_data_i);
        REG_WR_MOD:  wr_mod_q  <= ADDR_W'(reg_data_i);
        REG_WIDTH:   width_q   <= CNT_W'(reg_data_i);
        REG_LINES:   lines_q   <= CNT_W'(reg_data_i);
        REG_FILL:    fill_q    <= reg_data_i;
        REG_CTRL:    ; // start/abort handled by the engine state machine
        default:     ;
      endcase
    end
  end

  // Next-state logic: sequencing, pointer stepping and line counting
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    word_cnt_d = word_cnt_q;
    line_cnt_d = line_cnt_q;
    src_d      = src_q;
    mode_d     = mode_q;
`ifdef BLIT_TRANSPARENT_EN
    transp_d   = transp_q;
`endif
    step       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_req) begin
          mode_d = reg_data_i[1];
`ifdef BLIT_TRANSPARENT_EN
          transp_d = reg_data_i[2];
`endif
          if ((width_q == '0) || (lines_q == '0)) begin
            state_d = S_DONE;
          end else begin
            rd_ptr_d   = rd_addr_q;
            wr_ptr_d   = wr_addr_q;
            word_cnt_d = width_q;
            line_cnt_d = lines_q;
            state_d    = reg_data_i[1] ? S_RD_REQ : S_WR_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (blit_cycle_i) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        src_d   = blit_vram_data_i;
        state_d = S_WR_REQ;
      end
      S_WR_REQ: begin
        // A transparent word steps without waiting for a slot
        step = skip_wr || blit_cycle_i;
      end
      default: state_d = S_IDLE;
    endcase

    if (step) begin
      rd_ptr_d = next_ptr(rd_ptr_q, line_end, rd_mod_q);
      wr_ptr_d = next_ptr(wr_ptr_q, line_end, wr_mod_q);
      if (line_end && (line_cnt_q == CNT_W'(1))) begin
        state_d = S_DONE;
      end else begin
        state_d = mode_q ? S_RD_REQ : S_WR_REQ;
        if (line_end) begin
          word_cnt_d = width_q;
          line_cnt_d = line_cnt_q - CNT_W'(1);
        end else begin
          word_cnt_d = word_cnt_q - CNT_W'(1);
        end
      end
    end

    // Abort drops any outstanding read or pending write
    if (abort_req) state_d = S_DONE;
  end

  // Engine state registers
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      word_cnt_q <= '0;
      line_cnt_q <= '0;
      src_q      <= '0;
      mode_q     <= 1'b0;
`ifdef BLIT_TRANSPARENT_EN
      transp_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      word_cnt_q <= word_cnt_d;
      line_cnt_q <= line_cnt_d;
      src_q      <= src_d;
      mode_q     <= mode_d;
`ifdef BLIT_TRANSPARENT_EN
      transp_q   <= transp_d;
`endif
    end
  end

  // VRAM request decode; held stable in video slots because state does not move
  always_comb begin
    blit_vram_sel_o  = 1'b0;
    blit_vram_wr_o   = 1'b0;
    blit_vram_addr_o = '0;
    blit_vram_data_o = '0;
    case (state_q)
      S_RD_REQ: begin
        blit_vram_sel_o  = 1'b1;
        blit_vram_addr_o = rd_ptr_q;
      end
      S_WR_REQ: begin
        if (!skip_wr) begin
          blit_vram_sel_o  = 1'b1;
          blit_vram_wr_o   = 1'b1;
          blit_vram_addr_o = wr_ptr_q;
          blit_vram_data_o = mode_q ? src_q : fill_q;
        end
      end
      default: ;
    endcase
  end

  assign busy_o = busy;
  assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_blit2d_engine.sv
// Testbench for blit2d_engine: VRAM model, rectangle reference model, scenarios.
module tb_blit2d_engine;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

`ifdef BLIT_TRANSPARENT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        blit_cycle_i;
  logic        reg_write_strobe_i;
  logic [3:0]  reg_num_i;
  logic [15:0] reg_data_i;
  logic        blit_vram_sel_o;
  logic        blit_vram_wr_o;
  logic [15:0] blit_vram_addr_o;
  logic [15:0] blit_vram_data_o;
  logic [15:0] blit_vram_data_i;
  logic        busy_o;
  logic        done_o;

  logic [15:0] mem  [0:65535];
  logic [15:0] refm [0:65535];
  logic [15:0] rdata = 16'h0;
  wr_t         pl_q[$];
  wr_t         wq[$];
  logic [15:0] rq[$];
  wr_t         exp_q[$];
  logic [15:0] exp_rd[$];
  int          sel_cnt = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          bmode = 0;

  always #5 clk = ~clk;

  assign blit_vram_data_i = rdata;

  blit2d_engine #(.ADDR_W(16), .DATA_W(16), .CNT_W(16)) dut (
    .clk                (clk),
    .reset_n_i          (reset_n_i),
    .blit_cycle_i       (blit_cycle_i),
    .reg_write_strobe_i (reg_write_strobe_i),
    .reg_num_i          (reg_num_i),
    .reg_data_i         (reg_data_i),
    .blit_vram_sel_o    (blit_vram_sel_o),
    .blit_vram_wr_o     (blit_vram_wr_o),
    .blit_vram_addr_o   (blit_vram_addr_o),
    .blit_vram_data_o   (blit_vram_data_o),
    .blit_vram_data_i   (blit_vram_data_i),
    .busy_o             (busy_o),
    .done_o             (done_o)
  );

  // VRAM model: applies preloads, logs committed accesses, returns read data next cycle
  always @(posedge clk) begin
    while (pl_q.size() > 0) begin
      mem[pl_q[0].a] <= pl_q[0].d;
      void'(pl_q.pop_front());
    end
    if (blit_vram_sel_o) sel_cnt <= sel_cnt + 1;
    if (blit_vram_sel_o && blit_cycle_i) begin
      if (blit_vram_wr_o) begin
        mem[blit_vram_addr_o] <= blit_vram_data_o;
        wq.push_back({blit_vram_addr_o, blit_vram_data_o});
      end else begin
        rq.push_back(blit_vram_addr_o);
        rdata <= mem[blit_vram_addr_o];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    case (bmode)
      0:       blit_cycle_i = 1'b1;
      1:       blit_cycle_i = ~blit_cycle_i;
      default: blit_cycle_i = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic reg_wr(input logic [3:0] num, input logic [15:0] data);
    tick();
    reg_write_strobe_i = 1'b1;
    reg_num_i          = num;
    reg_data_i         = data;
    tick();
    reg_write_strobe_i = 1'b0;
  endtask

  task automatic setup(input logic [15:0] rd, wr, rdm, wrm, w, l, fill);
    reg_wr(4'd0, rd);
    reg_wr(4'd1, wr);
    reg_wr(4'd2, rdm);
    reg_wr(4'd3, wrm);
    reg_wr(4'd4, w);
    reg_wr(4'd5, l);
    reg_wr(4'd6, fill);
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_q.push_back({a, d});
    refm[a] = d;
  endtask

  task automatic wait_done(input int budget, output int busy_n, output bit ok);
    busy_n = 0;
    ok     = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (busy_o === 1'b1) busy_n++;
      tick();
    end
  endtask

  // Reference: word (li, wi) of the rectangle sits at base + li*(W+MOD) + wi,
  // mod 2^16. Copy reads then writes each word in raster order.
  task automatic model(input bit copy, input bit tr, input logic [15:0] rd, wr, rdm, wrm,
                       input int w, l, input logic [15:0] fill);
    int          sa_i, da_i;
    logic [15:0] sa, da, d;
    exp_q.delete();
    exp_rd.delete();
    for (int li = 0; li < l; li++) begin
      for (int wi = 0; wi < w; wi++) begin
        sa_i = int'(rd) + li * (w + int'(rdm)) + wi;
        da_i = int'(wr) + li * (w + int'(wrm)) + wi;
        sa   = sa_i[15:0];
        da   = da_i[15:0];
        if (copy) begin
          d = refm[sa];
          exp_rd.push_back(sa);
          if (!(TEN && tr && (d == fill))) begin
            exp_q.push_back({da, d});
            refm[da] = d;
          end
        end else begin
          exp_q.push_back({da, fill});
          refm[da] = fill;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b1;
    #2 reset_n_i = 1'b0;
    #1;
    n_cmp++; if (blit_vram_sel_o !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %b want 0", blit_vram_sel_o); end
    n_cmp++; if (blit_vram_wr_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", blit_vram_wr_o); end
    n_cmp++; if (blit_vram_addr_o !== 16'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", blit_vram_addr_o); end
    n_cmp++; if (blit_vram_data_o !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", blit_vram_data_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
    tick();
    tick();
    reset_n_i = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    int busy_n; bit ok;
    bmode = 0;
    setup(16'h0, 16'h0100, 16'h0, 16'd5, 16'd3, 16'd2, 16'h1F20);
    model(1'b0, 1'b0, 16'h0, 16'h0100, 16'h0, 16'd5, 3, 2, 16'h1F20);
    wq.delete();
    reg_wr(4'd7, 16'h0001);
    wait_done(200, busy_n, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL fill_done: no done_o within budget"); end
    n_cmp++; if (busy_n != 6) begin n_fail++; $display("FAIL fill_busy_cycles: got %0d want 6", busy_n); end
    tick();
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL fill_done_pulse: done_o still %b", done_o); end
    n_cmp++; if (wq.size() != exp_q.size()) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", wq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      n_cmp++;
      if (wq[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL fill_wr%0d: got %h=%h want %h=%h", i, wq[i].a, wq[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
  endtask

  task automatic test_copy();
    int busy_n; bit ok;
    bmode = 0;
    preload(16'h0010, 16'hAAAA);
    preload(16'h0011, 16'hBBBB);
    setup(16'h0010, 16'h2000, 16'h0, 16'h0, 16'd2, 16'd1, 16'h0000);
    model(1'b1, 1'b0, 16'h0010, 16'h2000, 16'h0, 16'h0, 2, 1, 16'h0000);
    wq.delete();
    rq.delete();
    reg_wr(4'd7, 16'h0003);
    wait_done(200, busy_n, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL copy_done: no done_o within budget"); end
    n_cmp++; if (busy_n != 6) begin n_fail++; $display("FAIL copy_busy_cycles: got %0d want 6", busy_n); end
    n_cmp++; if (rq.size() != exp_rd.size()) begin n_fail++; $display("FAIL copy_rd_count: got %0d want %0d", rq.size(), exp_rd.size()); end
    for (int i = 0; i < exp_rd.size() && i < rq.size(); i++) begin
      n_cmp++; if (rq[i] !== exp_rd[i]) begin n_fail++; $display("FAIL copy_rd%0d: got %h want %h", i, rq[i], exp_rd[i]); end
    end
    n_cmp++; if (wq.size() != exp_q.size()) begin n_fail++; $display("FAIL copy_count: got %0d want %0d", wq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      n_cmp++;
      if (wq[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL copy_wr%0d: got %h=%h want %h=%h", i, wq[i].a, wq[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
  endtask

  task automatic test_arbitration();
    bit          seen, psel, pwr, pblit, have_prev;
    logic [15:0] paddr, pdata;
    int          holds;
    bmode = 1;
    setup(16'h0, 16'h0400, 16'h0, 16'h0, 16'd4, 16'd1, 16'h5A5A);
    model(1'b0, 1'b0, 16'h0, 16'h0400, 16'h0, 16'h0, 4, 1, 16'h5A5A);
    wq.delete();
    reg_wr(4'd7, 16'h0001);
    seen = 1'b0; have_prev = 1'b0; holds = 0;
    for (int k = 0; k < 60; k++) begin
      if (done_o === 1'b1) begin seen = 1'b1; break; end
      if (have_prev && psel && !pblit) begin
        holds++;
        n_cmp++;
        if ({blit_vram_sel_o, blit_vram_wr_o, blit_vram_addr_o, blit_vram_data_o} !== {psel, pwr, paddr, pdata}) begin
          n_fail++;
          $display("FAIL arb_hold: got %b%b %h %h want %b%b %h %h", blit_vram_sel_o, blit_vram_wr_o,
                   blit_vram_addr_o, blit_vram_data_o, psel, pwr, paddr, pdata);
        end
      end
      psel = blit_vram_sel_o; pwr = blit_vram_wr_o; paddr = blit_vram_addr_o; pdata = blit_vram_data_o;
      pblit = blit_cycle_i; have_prev = 1'b1;
      tick();
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL arb_done: no done_o within budget"); end
    n_cmp++; if (holds < 3) begin n_fail++; $display("FAIL arb_hold_count: got %0d video-slot holds want >=3", holds); end
    n_cmp++; if (wq.size() != exp_q.size()) begin n_fail++; $display("FAIL arb_count: got %0d want %0d", wq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      n_cmp++;
      if (wq[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL arb_wr%0d: got %h=%h want %h=%h", i, wq[i].a, wq[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    bmode = 0;
    tick();
  endtask

  task automatic test_wrap_zero();
    int busy_n; bit ok; int s0;
    bmode = 0;
    setup(16'h0, 16'hFFFF, 16'h0, 16'h0, 16'd2, 16'd1, 16'h0F0F);
    model(1'b0, 1'b0, 16'h0, 16'hFFFF, 16'h0, 16'h0, 2, 1, 16'h0F0F);
    wq.delete();
    reg_wr(4'd7, 16'h0001);
    wait_done(100, busy_n, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL wrap_done: no done_o within budget"); end
    n_cmp++; if (wq.size() != exp_q.size()) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", wq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      n_cmp++;
      if (wq[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL wrap_wr%0d: got %h=%h want %h=%h", i, wq[i].a, wq[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    tick();
    // WIDTH = 0, then LINES = 0: done one cycle after start, no access
    reg_wr(4'd4, 16'd0);
    s0 = sel_cnt;
    reg_wr(4'd7, 16'h0001);
    n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL zero_w_done: got %b want 1", done_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL zero_w_busy: got %b want 0", busy_o); end
    tick(); tick();
    reg_wr(4'd4, 16'd3);
    reg_wr(4'd5, 16'd0);
    reg_wr(4'd7, 16'h0003);
    n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL zero_l_done: got %b want 1", done_o); end
    tick(); tick();
    n_cmp++; if (sel_cnt != s0) begin n_fail++; $display("FAIL zero_sel: got %0d sel cycles want 0", sel_cnt - s0); end
  endtask

  task automatic test_abort();
    int busy_n; bit ok; int k;
    bmode = 0;
    setup(16'h0, 16'h3000, 16'h0, 16'h0, 16'd100, 16'd1, 16'h0C0C);
    wq.delete();
    reg_wr(4'd7, 16'h0001);
    reg_wr(4'd1, 16'h7777); // ignored while busy
    k = 0;
    while (wq.size() < 10 && k < 200) begin tick(); k++; end
    n_cmp++; if (wq.size() != 10) begin n_fail++; $display("FAIL abort_reach10: got %0d writes want 10", wq.size()); end
    blit_cycle_i       = 1'b0;
    reg_write_strobe_i = 1'b1;
    reg_num_i          = 4'd7;
    reg_data_i         = 16'h8000;
    @(negedge clk);
    reg_write_strobe_i = 1'b0;
    blit_cycle_i       = 1'b1;
    n_cmp++; if (blit_vram_sel_o !== 1'b0) begin n_fail++; $display("FAIL abort_sel: got %b want 0", blit_vram_sel_o); end
    n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL abort_done: got %b want 1", done_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy_o); end
    tick(); tick(); tick();
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL abort_done_pulse: got %b want 0", done_o); end
    n_cmp++; if (wq.size() != 10) begin n_fail++; $display("FAIL abort_no_more: got %0d writes want 10", wq.size()); end
    for (int i = 0; i < 10 && i < wq.size(); i++) begin
      n_cmp++;
      if (wq[i] !== {16'h3000 + 16'(i), 16'h0C0C}) begin
        n_fail++; $display("FAIL abort_wr%0d: got %h=%h want %h=0c0c", i, wq[i].a, wq[i].d, 16'h3000 + 16'(i));
      end
    end
    // Start+abort together while idle: start wins; WR_ADDR write during busy was dropped
    model(1'b0, 1'b0, 16'h0, 16'h3000, 16'h0, 16'h0, 100, 1, 16'h0C0C);
    wq.delete();
    reg_wr(4'd7, 16'h8001);
    wait_done(400, busy_n, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL restart_done: no done_o within budget"); end
    n_cmp++; if (wq.size() != exp_q.size()) begin n_fail++; $display("FAIL restart_count: got %0d want %0d", wq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      n_cmp++;
      if (wq[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL restart_wr%0d: got %h=%h want %h=%h", i, wq[i].a, wq[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
  endtask

  task automatic test_transparent();
    int busy_n; bit ok;
    bmode = 0;
    preload(16'h0500, 16'h0000);
    preload(16'h0501, 16'h1234);
    preload(16'h0502, 16'h0000);
    setup(16'h0500, 16'h0600, 16'h0, 16'h0, 16'd3, 16'd1, 16'h0000);
    model(1'b1, 1'b1, 16'h0500, 16'h0600, 16'h0, 16'h0, 3, 1, 16'h0000);
    wq.delete();
    rq.delete();
    reg_wr(4'd7, 16'h0007);
    wait_done(200, busy_n, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL transp_done: no done_o within budget"); end
    n_cmp++; if (rq.size() != 3) begin n_fail++; $display("FAIL transp_rd_count: got %0d want 3", rq.size()); end
    n_cmp++; if (wq.size() != exp_q.size()) begin n_fail++; $display("FAIL transp_count: got %0d want %0d", wq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      n_cmp++;
      if (wq[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL transp_wr%0d: got %h=%h want %h=%h", i, wq[i].a, wq[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
  endtask

  task automatic test_reset_midop();
    int s0;
    bmode = 0;
    setup(16'h0, 16'h4000, 16'h0, 16'h0, 16'd50, 16'd1, 16'h7E7E);
    reg_wr(4'd7, 16'h0001);
    tick(); tick(); tick(); tick(); tick();
    #2 reset_n_i = 1'b0;
    #1;
    n_cmp++; if (blit_vram_sel_o !== 1'b0) begin n_fail++; $display("FAIL midrst_sel: got %b want 0", blit_vram_sel_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy_o); end
    n_cmp++; if (blit_vram_addr_o !== 16'h0) begin n_fail++; $display("FAIL midrst_addr: got %h want 0000", blit_vram_addr_o); end
    @(negedge clk);
    reset_n_i = 1'b1;
    tick();
    // Registers were cleared, so WIDTH=0 and a bare start finishes without access
    s0 = sel_cnt;
    reg_wr(4'd7, 16'h0001);
    n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL midrst_regs_cleared: done_o %b want 1", done_o); end
    tick(); tick(); tick();
    n_cmp++; if (sel_cnt != s0) begin n_fail++; $display("FAIL midrst_sel_after: got %0d sel cycles want 0", sel_cnt - s0); end
  endtask

  task automatic test_random();
    int busy_n; bit ok;
    bit copy, tr;
    logic [15:0] rd, wr, rdm, wrm, fill;
    int w, l, sa_i;
    bmode = 2;
    for (int t = 0; t < 10; t++) begin
      copy = 1'($urandom_range(0, 1));
      tr   = 1'($urandom_range(0, 1));
      rd   = 16'($urandom);
      wr   = 16'($urandom);
      rdm  = 16'($urandom_range(0, 8)) - 16'd3;
      wrm  = 16'($urandom_range(0, 8)) - 16'd3;
      w    = $urandom_range(1, 5);
      l    = $urandom_range(1, 4);
      fill = 16'($urandom_range(0, 3));
      if (copy) begin
        for (int li = 0; li < l; li++) begin
          for (int wi = 0; wi < w; wi++) begin
            sa_i = int'(rd) + li * (w + int'(rdm)) + wi;
            preload(sa_i[15:0], 16'($urandom_range(0, 5)));
          end
        end
      end
      setup(rd, wr, rdm, wrm, 16'(w), 16'(l), fill);
      model(copy, tr, rd, wr, rdm, wrm, w, l, fill);
      wq.delete();
      reg_wr(4'd7, {13'h0, tr, copy, 1'b1});
      wait_done(1000, busy_n, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL rand%0d_done: no done_o within budget", t); end
      n_cmp++; if (wq.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", t, wq.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
        n_cmp++;
        if (wq[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand%0d_wr%0d: got %h=%h want %h=%h", t, i, wq[i].a, wq[i].d, exp_q[i].a, exp_q[i].d);
        end
      end
      tick();
    end
    bmode = 0;
  endtask

  initial begin
    reset_n_i          = 1'b1;
    blit_cycle_i       = 1'b1;
    reg_write_strobe_i = 1'b0;
    reg_num_i          = 4'd0;
    reg_data_i         = 16'h0;
    test_reset();
    test_fill();
    test_copy();
    test_arbitration();
    test_wrap_zero();
    test_abort();
    test_transparent();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
